// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// MulticycleController
//   Multi-cycle sequencer for the 16-bit CPU datapath. Each instruction is
//   stepped through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK, and the
//   datapath controls are driven from the current state and the latched
//   opcode. The controller handshakes with a wait-state memory
//   (MemReq/MemReady) and with the iterative multiplier (MulStart/MulDone).
//
// Ports
//   Clock_i        system clock, rising edge
//   ResetN_i       asynchronous active-low reset
//   Opcode_i       instruction[15:13] from IR, only looked at in DECODE
//   MemReady_i     memory completes the current request this cycle
//   MulDone_i      multiplier result valid (single-cycle pulse)
//   PCWrite_o      PC <= PC+2
//   IRWrite_o      IR <= memory read data
//   IorD_o         memory address select (0 = PC, 1 = ALU result)
//   MemReq_o       memory request valid
//   MemRead_o      read request / read data select
//   MemWrite_o     write request
//   RegDst_o       register destination select (1 = rd, 0 = rt)
//   RegWrite_o     register-file write enable
//   MemToReg_o     writeback from memory data
//   ALUSrc_o       sign-extended immediate as ALU B operand
//   ALUOp_o        00 add, 01 sub (compare), 10 funct-decoded
//   Branch_o       PC <= target if ALU zero
//   MulStart_o     single-cycle multiplier start pulse
//   MulRegWrite_o  write multiplier result to register file
//   InstrRetired_o single-cycle pulse as an instruction completes
//   Halted_o       HALT executed, sticky until reset
//   Error_o        illegal opcode or multiply timeout, sticky until reset
//   State_o        current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter int MUL_TIMEOUT = 32,
   parameter int TCNT_W      = 6
) (
   input  logic       Clock_i,
   input  logic       ResetN_i,
   input  logic [2:0] Opcode_i,
   input  logic       MemReady_i,
   input  logic       MulDone_i,
   output logic       PCWrite_o,
   output logic       IRWrite_o,
   output logic       IorD_o,
   output logic       MemReq_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       RegDst_o,
   output logic       RegWrite_o,
   output logic       MemToReg_o,
   output logic       ALUSrc_o,
   output logic [1:0] ALUOp_o,
   output logic       Branch_o,
   output logic       MulStart_o,
   output logic       MulRegWrite_o,
   output logic       InstrRetired_o,
   output logic       Halted_o,
   output logic       Error_o,
   output logic [3:0] State_o
);

   typedef enum logic [3:0] {
      ST_RST      = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC     = 4'd3,
      ST_WB_ALU   = 4'd4,
      ST_MUL_WAIT = 4'd5,
      ST_MEMADDR  = 4'd6,
      ST_MEMACC   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_HALT     = 4'd10,
      ST_ERROR    = 4'd11
   } state_t;

   localparam logic [2:0] OP_RALU = 3'b000;
   localparam logic [2:0] OP_MUL  = 3'b001;
   localparam logic [2:0] OP_ADDI = 3'b010;
   localparam logic [2:0] OP_LW   = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b111;

   // Last watchdog value that is still allowed to wait for MulDone.
   localparam logic [TCNT_W-1:0] WD_LAST = TCNT_W'(MUL_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [2:0]        opReg_q;
   logic [TCNT_W-1:0] watchdog_q;
   logic              haltSeen_q;

   // State, latched opcode and multiply watchdog. The watchdog sits at zero
   // outside MUL_WAIT so every multiply starts counting from 0. haltSeen_q
   // marks that the first HALT cycle has passed, limiting the retire pulse
   // to the entry cycle.
   always_ff @(posedge Clock_i or negedge ResetN_i) begin
      if (!ResetN_i) begin
         state_q    <= ST_RST;
         opReg_q    <= '0;
         watchdog_q <= '0;
         haltSeen_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) begin
            opReg_q <= Opcode_i;
         end
         if (state_q == ST_MUL_WAIT) begin
            watchdog_q <= watchdog_q + 1'b1;
         end else begin
            watchdog_q <= '0;
         end
         haltSeen_q <= (state_q == ST_HALT);
      end
   end

   // Next-state and datapath controls. Everything is decoded from the state
   // and the latched opcode, except DECODE which must look at the live
   // opcode (it is only latched at the end of that cycle) and the handshake
   // cycles that react to MemReady / MulDone in the same cycle.
   always_comb begin
      state_d        = state_q;
      PCWrite_o      = 1'b0;
      IRWrite_o      = 1'b0;
      IorD_o         = 1'b0;
      MemReq_o       = 1'b0;
      MemRead_o      = 1'b0;
      MemWrite_o     = 1'b0;
      RegDst_o       = 1'b0;
      RegWrite_o     = 1'b0;
      MemToReg_o     = 1'b0;
      ALUSrc_o       = 1'b0;
      ALUOp_o        = 2'b00;
      Branch_o       = 1'b0;
      MulStart_o     = 1'b0;
      MulRegWrite_o  = 1'b0;
      InstrRetired_o = 1'b0;
      Halted_o       = 1'b0;
      Error_o        = 1'b0;
      case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            MemReq_o  = 1'b1;
            MemRead_o = 1'b1;
            if (MemReady_i) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               state_d   = ST_DECODE;
            end
         end
         ST_DECODE: begin
            case (Opcode_i)
               OP_RALU, OP_ADDI: state_d = ST_EXEC;
               OP_MUL: begin
                  MulStart_o = 1'b1;
                  state_d    = ST_MUL_WAIT;
               end
               OP_LW, OP_SW:     state_d = ST_MEMADDR;
               OP_BEQ:           state_d = ST_BRANCH;
               OP_HALT:          state_d = ST_HALT;
               default:          state_d = ST_ERROR;
            endcase
         end
         ST_EXEC: begin
            if (opReg_q == OP_RALU) begin
               ALUOp_o  = 2'b10;
               ALUSrc_o = 1'b0;
            end else begin
               ALUOp_o  = 2'b00;
               ALUSrc_o = 1'b1;
            end
            state_d = ST_WB_ALU;
         end
         ST_WB_ALU: begin
            RegWrite_o     = 1'b1;
            RegDst_o       = (opReg_q == OP_RALU);
            InstrRetired_o = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_MUL_WAIT: begin
            // A MulDone arriving on the last allowed cycle still retires.
            if (MulDone_i) begin
               MulRegWrite_o  = 1'b1;
               RegDst_o       = 1'b1;
               InstrRetired_o = 1'b1;
               state_d        = ST_FETCH;
            end else if (watchdog_q == WD_LAST) begin
               state_d = ST_ERROR;
            end
         end
         ST_MEMADDR: begin
            ALUSrc_o = 1'b1;
            ALUOp_o  = 2'b00;
            state_d  = ST_MEMACC;
         end
         ST_MEMACC: begin
            MemReq_o   = 1'b1;
            IorD_o     = 1'b1;
            MemRead_o  = (opReg_q == OP_LW);
            MemWrite_o = (opReg_q == OP_SW);
            if (MemReady_i) begin
               if (opReg_q == OP_LW) begin
                  state_d = ST_WB_MEM;
               end else begin
                  InstrRetired_o = 1'b1;
                  state_d        = ST_FETCH;
               end
            end
         end
         ST_WB_MEM: begin
            RegWrite_o     = 1'b1;
            MemToReg_o     = 1'b1;
            RegDst_o       = 1'b0;
            InstrRetired_o = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_BRANCH: begin
            Branch_o       = 1'b1;
            ALUOp_o        = 2'b01;
            ALUSrc_o       = 1'b0;
            InstrRetired_o = 1'b1;
            state_d        = ST_FETCH;
         end
         ST_HALT: begin
            Halted_o       = 1'b1;
            InstrRetired_o = !haltSeen_q;
         end
         ST_ERROR: begin
            Error_o = 1'b1;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase
   end

   assign State_o = state_q;

endmodule
